// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: reset / divider / lock sequencer for a dynamically divided PLLVR.
// Runs on the PLL reference clock so it never depends on the clock it reconfigures.
module pll_reconfig_ctrl #(
    parameter int unsigned INIT_FDIV    = 12,
    parameter int unsigned INIT_IDIV    = 5,
    parameter bit          INVERT_SEL   = 1'b1,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_STABLE  = 8,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_fdiv,
    input  logic [5:0] req_idiv,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_fdiv,
    output logic [5:0] pll_idiv,
    output logic       busy,
    output logic       locked,
    output logic       done,
    output logic       err_timeout,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_LOCKED,
        S_ERROR
    } state_t;

    localparam logic [5:0]  INIT_F    = 6'(INIT_FDIV);
    localparam logic [5:0]  INIT_I    = 6'(INIT_IDIV);
    localparam logic [5:0]  SEL_MASK  = INVERT_SEL ? 6'h3F : 6'h00;
    localparam logic [7:0]  HOLD_END  = 8'(RESET_CYCLES - 1);
    localparam logic [7:0]  STAB_END  = 8'(LOCK_STABLE - 1);
    localparam logic [19:0] TOUT_END  = 20'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state;
    state_t      next_state;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic [7:0]  hold_cnt;
    logic [7:0]  stable_cnt;
    logic [19:0] tout_cnt;
    logic [3:0]  retry_cnt;
    logic [5:0]  fdiv_r;
    logic [5:0]  idiv_r;
    logic        accept;
    logic        hold_end;
    logic        stable_hit;
    logic        tout_hit;
    logic        lock_drop;
    logic        reset_d;
    logic        ready_d;
    logic        busy_d;
    logic        locked_d;
    logic        err_d;
    logic        done_d;
    logic        lost_d;

    // pll_lock is asynchronous to clkin
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    assign lock_s     = sync_q[1];
    assign accept     = req_valid & req_ready;
    assign hold_end   = (state == S_HOLD) && (hold_cnt == HOLD_END);
    assign stable_hit = (state == S_WAIT) && lock_s
                        && (stable_cnt == STAB_END);
    assign tout_hit   = (state == S_WAIT) && (tout_cnt == TOUT_END);
    assign lock_drop  = (state == S_LOCKED) && !lock_s;

    assign pll_fdiv = fdiv_r ^ SEL_MASK;
    assign pll_idiv = idiv_r ^ SEL_MASK;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= S_HOLD;
            pll_reset   <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            locked      <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= next_state;
            pll_reset   <= reset_d;
            req_ready   <= ready_d;
            busy        <= busy_d;
            locked      <= locked_d;
            done        <= done_d;
            err_timeout <= err_d;
            lock_lost   <= lost_d;
        end
    end

    // stability beats a simultaneous timeout; accept beats a lock drop
    always_comb begin
        next_state = state;
        unique case (state)
            S_HOLD: begin
                if (hold_end) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (stable_hit) begin
                    next_state = S_LOCKED;
                end else if (tout_hit) begin
                    if (retry_cnt < RETRY_MAX) next_state = S_HOLD;
                    else next_state = S_ERROR;
                end
            end
            S_LOCKED: begin
                if (accept || !lock_s) next_state = S_HOLD;
            end
            S_ERROR: begin
                if (accept) next_state = S_HOLD;
            end
            default: next_state = S_HOLD;
        endcase
    end

    always_comb begin
        reset_d  = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        locked_d = 1'b0;
        err_d    = 1'b0;
        unique case (next_state)
            S_HOLD: begin
                reset_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                busy_d = 1'b1;
            end
            S_LOCKED: begin
                ready_d  = 1'b1;
                locked_d = 1'b1;
            end
            S_ERROR: begin
                reset_d = 1'b1;
                ready_d = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                reset_d = 1'b1;
            end
        endcase
        done_d = (state == S_WAIT) && (next_state == S_LOCKED);
        lost_d = lock_drop && !accept;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            fdiv_r     <= INIT_F;
            idiv_r     <= INIT_I;
            hold_cnt   <= 8'd0;
            stable_cnt <= 8'd0;
            tout_cnt   <= 20'd0;
            retry_cnt  <= 4'd0;
        end else begin
            if (accept) begin
                fdiv_r <= req_fdiv;
                idiv_r <= req_idiv;
            end
            if ((state == S_HOLD) && !hold_end) hold_cnt <= hold_cnt + 8'd1;
            else hold_cnt <= 8'd0;
            if (state == S_WAIT) begin
                tout_cnt <= tout_cnt + 20'd1;
                if (lock_s) stable_cnt <= stable_cnt + 8'd1;
                else stable_cnt <= 8'd0;
            end else begin
                tout_cnt   <= 20'd0;
                stable_cnt <= 8'd0;
            end
            if (stable_hit || accept || lock_drop) begin
                retry_cnt <= 4'd0;
            end else if (tout_hit && (retry_cnt < RETRY_MAX)) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: randomized lock-delay / request bench for pll_reconfig_ctrl.
// Expected phase lengths and outcomes come from a transaction-level model.
module tb_pll_reconfig_ctrl;

    localparam int RC   = 4;
    localparam int STB  = 3;
    localparam int TOUT = 20;
    localparam int MAXR = 2;
    localparam logic [5:0] INIT_F = 6'd12;
    localparam logic [5:0] INIT_I = 6'd5;
    localparam logic [18:0] EXP_RST = {1'b1, ~INIT_F, ~INIT_I, 6'b010000};

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [5:0] req_fdiv = 6'd0;
    logic [5:0] req_idiv = 6'd0;
    logic       pll_lock = 1'b0;
    logic       req_ready, pll_reset, busy, locked;
    logic       done, err_timeout, lock_lost;
    logic [5:0] pll_fdiv, pll_idiv;
    logic [18:0] obs;

    int n_pass = 0;
    int n_chk  = 0;
    int lk_delay = 0;
    int lk_cnt = 0;
    bit drop_now = 1'b0;
    bit ok = 1'b0;
    bit mdl_locked = 1'b0;
    logic [5:0] cur_f, cur_i;

    pll_reconfig_ctrl #(
        .INIT_FDIV(12), .INIT_IDIV(5), .INVERT_SEL(1'b1),
        .RESET_CYCLES(RC), .LOCK_STABLE(STB),
        .LOCK_TIMEOUT(TOUT), .MAX_RETRIES(MAXR)
    ) dut (
        .clkin(clkin), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fdiv(req_fdiv), .req_idiv(req_idiv),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_fdiv(pll_fdiv), .pll_idiv(pll_idiv),
        .busy(busy), .locked(locked), .done(done),
        .err_timeout(err_timeout), .lock_lost(lock_lost)
    );

    assign obs = {pll_reset, pll_fdiv, pll_idiv, req_ready,
                  busy, locked, done, err_timeout, lock_lost};

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [5:0] enc(input logic [5:0] v);
        return ~v;
    endfunction

    function automatic int pick_delay();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 20));
    endfunction

    // PLL model: lock low in reset, high lk_delay cycles after release
    task automatic tick();
        @(negedge clkin);
        if (pll_reset) begin
            lk_cnt = 0;
            pll_lock = 1'b0;
        end else begin
            lk_cnt++;
            pll_lock = (lk_delay > 0) && (lk_cnt >= lk_delay) && !drop_now;
        end
    endtask

    task automatic run_seq(input logic [5:0] f, input logic [5:0] i,
                           input int dfix, input int skip,
                           input bit ll_exp, output bit good);
        int hc, wc, ll, rdy, d, exp_w;
        bit exp_ok;
        good = 1'b0;
        for (int a = 0; a <= MAXR; a++) begin
            d = (dfix >= 0) ? dfix : pick_delay();
            lk_delay = d;
            hc = (a == 0) ? skip : 0;
            ll = 0;
            rdy = 0;
            check("div_fb", pll_fdiv, enc(f));
            check("div_in", pll_idiv, enc(i));
            while (pll_reset && busy && hc < 100) begin
                ll += int'(lock_lost);
                rdy += int'(req_ready);
                hc++;
                tick();
            end
            check("hold_len", hc, RC);
            if (a == 0) check("lost_pulses", ll, int'(ll_exp));
            wc = 0;
            while (busy && !pll_reset && wc < 100) begin
                rdy += int'(req_ready);
                wc++;
                tick();
            end
            check("ready_busy", rdy, 0);
            check("div_hold", {pll_fdiv, pll_idiv}, {enc(f), enc(i)});
            exp_ok = (d > 0) && (d + 1 + STB <= TOUT);
            exp_w = exp_ok ? d + 1 + STB : TOUT;
            check("wait_len", wc, exp_w);
            if (exp_ok) begin
                check("lock_entry",
                      {locked, done, req_ready, pll_reset, busy}, 5'b11100);
                good = 1'b1;
                return;
            end
            if (a < MAXR)
                check("retry_hold", {pll_reset, busy, err_timeout}, 3'b110);
            else
                check("error_state",
                      {err_timeout, pll_reset, req_ready, busy, locked},
                      5'b11100);
        end
    endtask

    task automatic settle();
        tick();
        check("done_once", {done, locked}, 2'b01);
    endtask

    task automatic seq(input int dfix, input int skip, input bit ll_exp);
        run_seq(cur_f, cur_i, dfix, skip, ll_exp, ok);
        mdl_locked = ok;
        if (ok) settle();
    endtask

    task automatic do_req(input logic [5:0] f, input logic [5:0] i);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_fdiv = f;
        req_idiv = i;
        while (!req_ready && n < 200) begin
            n++;
            tick();
        end
        check("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_fdiv = 6'($urandom);
        req_idiv = 6'($urandom);
        check("accept",
              {pll_reset, busy, req_ready, err_timeout, locked}, 5'b11000);
        cur_f = f;
        cur_i = i;
    endtask

    task automatic lose_lock(input bit with_req, input logic [5:0] f,
                             input logic [5:0] i, input int dfix);
        drop_now = 1'b1;
        tick();
        drop_now = 1'b0;
        tick();
        tick();
        check("still_locked", locked, 1);
        if (with_req) begin
            req_valid = 1'b1;
            req_fdiv = f;
            req_idiv = i;
        end
        tick();
        req_valid = 1'b0;
        check("lost_exit", {pll_reset, busy, locked, lock_lost},
              with_req ? 4'b1100 : 4'b1101);
        if (with_req) begin
            cur_f = f;
            cur_i = i;
        end
        seq(dfix, 0, !with_req);
    endtask

    initial begin
        logic [5:0] f, i;
        int k;
        reset = 1'b1;
        tick();
        tick();
        check("reset_vals", obs, EXP_RST);
        reset = 1'b0;
        cur_f = INIT_F;
        cur_i = INIT_I;
        check("pu_enc", {pll_fdiv, pll_idiv}, {6'h33, 6'h3A});
        seq(5, 0, 1'b0);

        do_req(6'd20, 6'd3);
        check("reconf_enc", {pll_fdiv, pll_idiv}, {6'h2B, 6'h3C});
        seq(5, 0, 1'b0);

        // request held through the whole sequence, data changed once
        do_req(6'd7, 6'd9);
        req_valid = 1'b1;
        req_fdiv = 6'd40;
        req_idiv = 6'd1;
        tick();
        check("bp_ready", req_ready, 0);
        req_fdiv = 6'd33;
        req_idiv = 6'd2;
        run_seq(cur_f, cur_i, 5, 1, 1'b0, ok);
        tick();
        req_valid = 1'b0;
        check("bp_latch", {pll_fdiv, pll_idiv, pll_reset},
              {enc(6'd33), enc(6'd2), 1'b1});
        cur_f = 6'd33;
        cur_i = 6'd2;
        seq(5, 0, 1'b0);

        do_req(6'd15, 6'd6);
        seq(0, 0, 1'b0);
        repeat (3) tick();
        check("err_hold", {err_timeout, pll_reset, req_ready}, 3'b111);
        do_req(6'd63, 6'd0);
        seq(16, 0, 1'b0);
        do_req(6'd1, 6'd62);
        seq(17, 0, 1'b0);
        do_req(6'd30, 6'd4);
        seq(5, 0, 1'b0);

        lose_lock(1'b0, 6'd0, 6'd0, 5);
        lose_lock(1'b1, 6'd45, 6'd17, 5);

        for (int n = 0; n < 24; n++) begin
            k = int'($urandom_range(0, 2));
            if (!mdl_locked) k = 0;
            f = 6'($urandom);
            i = 6'($urandom);
            case (k)
                0: begin
                    do_req(f, i);
                    seq(-1, 0, 1'b0);
                end
                1: lose_lock(1'b0, f, i, -1);
                default: lose_lock(1'b1, f, i, -1);
            endcase
        end

        // asynchronous reset in the middle of WAIT_LOCK
        do_req(6'd50, 6'd11);
        lk_delay = 0;
        repeat (RC + 1) tick();
        check("in_wait", {busy, pll_reset}, 2'b10);
        #3 reset = 1'b1;
        #1 check("async_rst", obs, EXP_RST);
        tick();
        reset = 1'b0;
        cur_f = INIT_F;
        cur_i = INIT_I;
        seq(5, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
